bird_plotter: RTL
=================

# bird_plotter

Frame-buffer writer for the flappy-bird sprite. Accepts a bird vertical position from the bird control FSM through a valid/ready handshake. Erases the sprite at its previously drawn position and redraws it at the new one, emitting one pixel write per cycle to the VGA adapter (x, y, colour, plot). Sits between the bird control logic and the VGA adapter as the consumer of the bird's y position.

## Interface
- X_POS, 20: fixed sprite left column (8-bit screen x).
- BIRD_W, 4: sprite width in pixels, 1..8.
- BIRD_H, 4: sprite height in pixels, 1..8.
- Y_MAX, 119: last screen row.
- BIRD_COLOUR, 3'b110: sprite fill colour.
- BG_COLOUR, 3'b000: erase colour.
- OUTLINE_COLOUR, 3'b100: border colour, used only with BIRD_PLOTTER_OUTLINE_EN.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- resetn  in  1  reset, synchronous, active-low.
- y_in  in  7  requested sprite top row.
- y_valid  in  1  y_in valid this cycle.
- ready  out  1  block idle and able to accept; reset 1.
- x_out  out  8  pixel column; reset 0.
- y_out  out  7  pixel row; reset 0.
- colour  out  3  pixel colour; reset 0.
- plot  out  1  pixel write strobe, one pixel per high cycle; reset 0.
- done  out  1  one-cycle pulse when an update completes; reset 0.

## Operation
- States: IDLE, ERASE, DRAW, DONE.
- IDLE: ready=1, plot=0. On y_valid&&ready, latch y_new = min(y_in, Y_MAX-BIRD_H+1).
  - If have_old=1 and y_new==y_old, go to DONE with no plots.
  - Else if have_old=1, go to ERASE.
  - Else go to DRAW.
- ERASE: scan rectangle at (X_POS, y_old), BIRD_W×BIRD_H pixels, colour BG_COLOUR. After the last pixel, go to DRAW.
- DRAW: scan rectangle at (X_POS, y_new), colour BIRD_COLOUR. After the last pixel, set y_old=y_new and have_old=1, then go to DONE.
- DONE: done=1 for one cycle, ready=1, then IDLE.
- Scan order: row-major from the top-left. cx counts 0..BIRD_W-1 (inner), cy counts 0..BIRD_H-1 (outer). x_out=X_POS+cx, y_out=y+cy. Counters reset to 0 on entry to each scan.
- x_out, y_out, colour and plot are registered. Values are don't-care-held when plot=0.
- ready=0 in ERASE and DRAW. y_valid is ignored there, not queued.
- Arithmetic: 7-bit row adds. The clamp guarantees y_out ≤ Y_MAX, so there is no wrap.
- Reset at any time: next edge gives IDLE, plot=0, done=0, have_old=0, y_old=0, and all outputs at reset values. A partially drawn sprite is left on screen. The first update after reset does not erase it.

## Timing
- Accept edge k, with y_valid&&ready sampled high.
- Fresh draw (N=BIRD_W·BIRD_H): plot high cycles k+1..k+N, done high cycle k+N+1, ready low k+1..k+N.
- Erase + draw: erase plots k+1..k+N, draw plots k+N+1..k+2N contiguous with no gap, done at k+2N+1.
- Same-y update: done at k+1, no plots.
- Back-to-back requests: a request presented during the DONE cycle is accepted at that edge. Minimum spacing is therefore N+1 cycles (fresh draw) or 2N+1 cycles (erase + draw).

## Configuration
- BIRD_PLOTTER_OUTLINE_EN defined:
  - In DRAW, pixels with cx∈{0,BIRD_W-1} or cy∈{0,BIRD_H-1} use OUTLINE_COLOUR; all others use BIRD_COLOUR.
  - ERASE is unchanged.
  - Timing is unchanged.
- Undefined: DRAW pixels are all BIRD_COLOUR. OUTLINE_COLOUR is unused.

## Test plan
- Reset, then y_in=50 valid one cycle -> 16 plots at x 20..23, y 50..53, colour 110, row-major; done one cycle later, at k+17.
- After the previous test, y_in=52 -> 16 plots at y 50..53 colour 000, then 16 plots at y 52..55 colour 110; done at k+33.
- y_in=127 -> drawn at rows 116..119, no y_out >119.
- Repeat y_in=52 when y_old=52 -> zero plots, done at k+1. Also: y_valid held during DRAW is not accepted until the DONE cycle.
- resetn low for one cycle at the 5th draw plot -> plot=0 next cycle, ready=1. Then y_in=10 -> 16 draw plots only, no erase.
- With BIRD_PLOTTER_OUTLINE_EN, y_in=30 -> 12 border pixels colour 100 and interior (21..22, 31..32) colour 110.

Source files
------------

// File: rtl/bird_plotter.sv
// bird_plotter: erases the bird sprite at its last drawn row and redraws it at a new row,
//   emitting one frame-buffer pixel write per cycle (x_out, y_out, colour, plot) to the VGA adapter.
// Latency: first plot the cycle after acceptance; done after N (fresh) or 2N (erase+draw) plots, N=BIRD_W*BIRD_H.
// Backpressure: ready is low while plotting; y_valid is ignored then (not queued). A request in the DONE cycle is accepted.
// Ports: clk, resetn (sync, active-low) | y_in[6:0], y_valid, ready | x_out[7:0], y_out[6:0], colour[2:0], plot, done.
// Build option: define BIRD_PLOTTER_OUTLINE_EN to draw the sprite border in OUTLINE_COLOUR.
module bird_plotter #(
  parameter int         X_POS          = 20,
  parameter int         BIRD_W         = 4,
  parameter int         BIRD_H         = 4,
  parameter int         Y_MAX          = 119,
  parameter logic [2:0] BIRD_COLOUR    = 3'b110,
  parameter logic [2:0] BG_COLOUR      = 3'b000,
  parameter logic [2:0] OUTLINE_COLOUR = 3'b100
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [6:0] y_in,
  input  logic       y_valid,
  output logic       ready,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour,
  output logic       plot,
  output logic       done
);

`ifdef BIRD_PLOTTER_OUTLINE_EN
  localparam bit OUTLINE_EN = 1'b1;
`else
  localparam bit OUTLINE_EN = 1'b0;
`endif

  localparam logic [7:0] X_BASE  = 8'(X_POS);
  localparam logic [6:0] Y_TOP   = 7'(Y_MAX - BIRD_H + 1);  // highest legal sprite top row
  localparam logic [2:0] CX_LAST = 3'(BIRD_W - 1);
  localparam logic [2:0] CY_LAST = 3'(BIRD_H - 1);

  typedef enum logic [1:0] {S_IDLE, S_ERASE, S_DRAW, S_DONE} state_t;

  state_t     r_state, w_state_nxt;
  logic [2:0] r_cx, r_cy, w_cx_nxt, w_cy_nxt, w_cx_adv, w_cy_adv;
  logic [6:0] r_y_base, w_y_base_nxt;   // top row of the rectangle being scanned
  logic [6:0] r_y_new, w_y_new_nxt;
  logic [6:0] r_y_old, w_y_old_nxt;
  logic       r_have_old, w_have_old_nxt;
  logic [7:0] r_x_out;
  logic [6:0] r_y_out;
  logic [2:0] r_colour, w_colour_nxt;
  logic       r_plot, w_plot_nxt;
  logic       w_last, w_accept;
  logic [6:0] w_y_clamp;

  function automatic logic [2:0] f_draw_colour(input logic [2:0] cx, input logic [2:0] cy);
    logic border;
    border = (cx == 3'd0) || (cx == CX_LAST) || (cy == 3'd0) || (cy == CY_LAST);
    return (OUTLINE_EN && border) ? OUTLINE_COLOUR : BIRD_COLOUR;
  endfunction

  assign ready  = (r_state == S_IDLE) || (r_state == S_DONE);
  assign done   = (r_state == S_DONE);
  assign x_out  = r_x_out;
  assign y_out  = r_y_out;
  assign colour = r_colour;
  assign plot   = r_plot;

  assign w_accept  = y_valid && ready;
  assign w_y_clamp = (y_in > Y_TOP) ? Y_TOP : y_in;
  assign w_last    = (r_cx == CX_LAST) && (r_cy == CY_LAST);
  // Row-major step: cx is the inner counter.
  assign w_cx_adv  = (r_cx == CX_LAST) ? 3'd0 : r_cx + 3'd1;
  assign w_cy_adv  = (r_cx == CX_LAST) ? r_cy + 3'd1 : r_cy;

  // Next-state logic. The counters always name the pixel held in the output registers,
  // so the first pixel of a scan is loaded on the edge that enters the scan state.
  always_comb begin
    w_state_nxt    = r_state;
    w_cx_nxt       = r_cx;
    w_cy_nxt       = r_cy;
    w_y_base_nxt   = r_y_base;
    w_y_new_nxt    = r_y_new;
    w_y_old_nxt    = r_y_old;
    w_have_old_nxt = r_have_old;
    w_colour_nxt   = r_colour;
    w_plot_nxt     = 1'b0;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
          w_y_new_nxt = w_y_clamp;
          w_cx_nxt    = 3'd0;
          w_cy_nxt    = 3'd0;
          if (r_have_old && (w_y_clamp == r_y_old)) begin
            w_state_nxt = S_DONE;
          end else if (r_have_old) begin
            w_state_nxt  = S_ERASE;
            w_y_base_nxt = r_y_old;
            w_colour_nxt = BG_COLOUR;
            w_plot_nxt   = 1'b1;
          end else begin
            w_state_nxt  = S_DRAW;
            w_y_base_nxt = w_y_clamp;
            w_colour_nxt = f_draw_colour(3'd0, 3'd0);
            w_plot_nxt   = 1'b1;
          end
        end else if (r_state == S_DONE) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ERASE: begin
        w_plot_nxt = 1'b1;
        if (w_last) begin
          // Draw follows with no gap cycle.
          w_state_nxt  = S_DRAW;
          w_cx_nxt     = 3'd0;
          w_cy_nxt     = 3'd0;
          w_y_base_nxt = r_y_new;
          w_colour_nxt = f_draw_colour(3'd0, 3'd0);
        end else begin
          w_cx_nxt     = w_cx_adv;
          w_cy_nxt     = w_cy_adv;
          w_colour_nxt = BG_COLOUR;
        end
      end
      S_DRAW: begin
        if (w_last) begin
          w_state_nxt    = S_DONE;
          w_y_old_nxt    = r_y_new;
          w_have_old_nxt = 1'b1;
        end else begin
          w_plot_nxt   = 1'b1;
          w_cx_nxt     = w_cx_adv;
          w_cy_nxt     = w_cy_adv;
          w_colour_nxt = f_draw_colour(w_cx_adv, w_cy_adv);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_cx       <= 3'd0;
      r_cy       <= 3'd0;
      r_y_base   <= 7'd0;
      r_y_new    <= 7'd0;
      r_y_old    <= 7'd0;
      r_have_old <= 1'b0;
      r_x_out    <= 8'd0;
      r_y_out    <= 7'd0;
      r_colour   <= 3'd0;
      r_plot     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cx       <= w_cx_nxt;
      r_cy       <= w_cy_nxt;
      r_y_base   <= w_y_base_nxt;
      r_y_new    <= w_y_new_nxt;
      r_y_old    <= w_y_old_nxt;
      r_have_old <= w_have_old_nxt;
      r_plot     <= w_plot_nxt;
      // Pixel outputs hold their last value while plot is low.
      if (w_plot_nxt) begin
        r_x_out  <= X_BASE + 8'(w_cx_nxt);
        r_y_out  <= w_y_base_nxt + 7'(w_cy_nxt);
        r_colour <= w_colour_nxt;
      end
    end
  end

endmodule
